// File: rtl/hpi_target.sv
// HPI device-side responder: synchronises the host strobes and serves the DATA, MAILBOX,
// ADDRESS and STATUS registers. DATA is backed by word RAM with an auto-incrementing byte pointer.
module hpi_target #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hpi_cs_n,
    input  logic        hpi_rd_n,
    input  logic        hpi_wr_n,
    input  logic [1:0]  hpi_addr,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        hpi_int,
    output logic [15:0] mbx_to_local,
    output logic        mbx_to_local_valid,
    input  logic        mbx_to_local_ack,
    input  logic [15:0] mbx_from_local,
    input  logic        mbx_from_local_wr,
    output logic        mbx_from_local_full
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MBX  = 2'd1;
    localparam logic [1:0] REG_ADDR = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    logic        r_cs_m, r_cs_s, r_rd_m, r_rd_s, r_wr_m, r_wr_s;
    logic [1:0]  r_addr_m, r_addr_s;
    logic [15:0] r_din_m, r_din_s;
    logic        r_rd_act_d, r_wr_act_d;
    state_t      r_state, w_state_nx;
    logic [1:0]  r_sel;
    logic        r_rd_load;
    logic [15:0] r_wdata;
    logic [15:0] r_addr_ptr;
    logic [15:0] r_data_out;
    logic        r_data_oe;
    logic [15:0] r_mbx_in, r_mbx_out;
    logic        r_mbx_in_full, r_mbx_out_full;
    logic        r_int;
    logic [15:0] r_ram [DEPTH];
    logic [15:0] r_ram_q;

    logic           w_rd_act, w_wr_act, w_rd_rise, w_wr_rise, w_rd_fall, w_wr_fall;
    logic           w_start, w_rd_commit, w_wr_commit;
    logic           w_ram_we, w_mbx_rd_commit, w_out_full_cleared;
    logic [AW-1:0]  w_ram_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_m   <= 1'b0;
            r_cs_s   <= 1'b0;
            r_rd_m   <= 1'b0;
            r_rd_s   <= 1'b0;
            r_wr_m   <= 1'b0;
            r_wr_s   <= 1'b0;
            r_addr_m <= '0;
            r_addr_s <= '0;
            r_din_m  <= '0;
            r_din_s  <= '0;
        end else begin
            r_cs_m   <= hpi_cs_n;
            r_cs_s   <= r_cs_m;
            r_rd_m   <= hpi_rd_n;
            r_rd_s   <= r_rd_m;
            r_wr_m   <= hpi_wr_n;
            r_wr_s   <= r_wr_m;
            r_addr_m <= hpi_addr;
            r_addr_s <= r_addr_m;
            r_din_m  <= hpi_data_in;
            r_din_s  <= r_din_m;
        end
    end

    assign w_rd_act  = ~r_cs_s & ~r_rd_s;
    assign w_wr_act  = ~r_cs_s & ~r_wr_s;
    assign w_rd_rise = w_rd_act & ~r_rd_act_d;
    assign w_wr_rise = w_wr_act & ~r_wr_act_d;
    assign w_rd_fall = ~w_rd_act & r_rd_act_d;
    assign w_wr_fall = ~w_wr_act & r_wr_act_d;

    // Delayed strobes come out of reset "already active" so a strobe held low across reset
    // must go high and low again before it counts as a new access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_act_d <= 1'b1;
            r_wr_act_d <= 1'b1;
            r_state    <= S_IDLE;
        end else begin
            r_rd_act_d <= w_rd_act;
            r_wr_act_d <= w_wr_act;
            r_state    <= w_state_nx;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nx  = r_state;
        w_start     = 1'b0;
        w_rd_commit = 1'b0;
        w_wr_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_rise) begin
                    w_state_nx = S_WR;
                    w_start    = 1'b1;
                end else if (w_rd_rise) begin
                    w_state_nx = S_RD;
                    w_start    = 1'b1;
                end
            end
            S_RD: if (w_rd_fall) begin
                w_state_nx  = S_IDLE;
                w_rd_commit = 1'b1;
            end
            S_WR: if (w_wr_fall) begin
                w_state_nx  = S_IDLE;
                w_wr_commit = 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_ram_idx          = r_addr_ptr[AW:1];
    assign w_ram_we           = w_wr_commit && (r_sel == REG_DATA);
    assign w_mbx_rd_commit    = w_rd_commit && (r_sel == REG_MBX);
    // Host read clears first, so a coincident local load still lands.
    assign w_out_full_cleared = r_mbx_out_full & ~w_mbx_rd_commit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel          <= '0;
            r_rd_load      <= 1'b0;
            r_wdata        <= '0;
            r_addr_ptr     <= '0;
            r_data_out     <= '0;
            r_data_oe      <= 1'b0;
            r_mbx_in       <= '0;
            r_mbx_in_full  <= 1'b0;
            r_mbx_out      <= '0;
            r_mbx_out_full <= 1'b0;
            r_int          <= 1'b0;
        end else begin
            if (w_start) r_sel <= r_addr_s;
            r_rd_load <= w_start && (w_state_nx == S_RD);
            if (w_wr_act) r_wdata <= r_din_s;
            r_data_oe <= (w_state_nx == S_RD);

            if (r_rd_load) begin
                case (r_sel)
                    REG_DATA: r_data_out <= r_ram_q;
                    REG_MBX:  r_data_out <= r_mbx_out;
                    REG_ADDR: r_data_out <= r_addr_ptr;
                    REG_STAT: r_data_out <= {14'b0, r_mbx_out_full, r_mbx_in_full};
                    default:  r_data_out <= '0;
                endcase
            end

            if ((w_rd_commit && r_sel == REG_DATA) || w_ram_we)
                r_addr_ptr <= r_addr_ptr + 16'd2;
            else if (w_wr_commit && r_sel == REG_ADDR)
                r_addr_ptr <= r_wdata;

            if (w_wr_commit && r_sel == REG_MBX) begin
                r_mbx_in      <= r_wdata;
                r_mbx_in_full <= 1'b1;
            end else if (mbx_to_local_ack) begin
                r_mbx_in_full <= 1'b0;
            end

            if (mbx_from_local_wr && !w_out_full_cleared) begin
                r_mbx_out      <= mbx_from_local;
                r_mbx_out_full <= 1'b1;
            end else begin
                r_mbx_out_full <= w_out_full_cleared;
            end

            r_int <= r_mbx_out_full;
        end
    end

    // NOTE: RAM contents and its read register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_ram_idx] <= r_wdata;
        r_ram_q <= r_ram[w_ram_idx];
    end

    assign hpi_data_out        = r_data_out;
    assign hpi_data_oe         = r_data_oe;
    assign hpi_int             = r_int;
    assign mbx_to_local        = r_mbx_in;
    assign mbx_to_local_valid  = r_mbx_in_full;
    assign mbx_from_local_full = r_mbx_out_full;

endmodule
